// File: rtl/gray_counter_pkg.sv
// Shared types and helpers for the Gray counter slice.
// Holds the default width, the snapshot FSM state encoding and the binary-to-Gray helper.
// Used by: gray_counter_if, bin_to_gray, gray_counter.
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 32;

  typedef enum logic {S_IDLE, S_HOLD} snap_state_t;

  // Reflected Gray encoding on a full 32-bit word. The caller truncates to its own width.
  // This is safe because the bits above the caller's width are zero, so the top kept bit
  // is just b[W-1].
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Snapshot handshake bundle between the Gray counter and a slower consumer.
// Latency: n/a (wires only).
// Backpressure: snap_valid/snap_data are held by the master until snap_ready.
// master: counter side (drives snap_valid, snap_data).
// slave: consumer side (drives snap_req, snap_ready).
interface gray_counter_if #(
  parameter int WIDTH = gray_pkg::GRAY_W_DEFAULT
) ();

  logic             snap_req;
  logic             snap_valid;
  logic             snap_ready;
  logic [WIDTH-1:0] snap_data;

  modport master (
    input  snap_req,
    input  snap_ready,
    output snap_valid,
    output snap_data
  );

  modport slave (
    output snap_req,
    output snap_ready,
    input  snap_valid,
    input  snap_data
  );

endinterface

// File: rtl/gray_counter_bin_to_gray.sv
// Combinational binary-to-reflected-Gray encoder.
// Latency: 0 cycles (pure logic).
// Backpressure: none.
// Ports: bin (binary in, WIDTH), gray (Gray out, WIDTH).
module bin_to_gray
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = WIDTH'(bin2gray(32'(bin)));

endmodule

// File: rtl/gray_counter.sv
// Registered up/down binary counter published as reflected Gray code, with a snapshot port.
// Latency: o and wrap update on the edge that samples the controls. The snapshot captures
//   the pre-edge value of o.
// Backpressure: snap_data/snap_valid are held until snap_ready. Counting never stalls.
// Ports: clk, rst (sync, active-high), en, down, load, d -> o (Gray), wrap (1-cycle pulse),
//   snap (gray_counter_if.master).
// Optional build macro GRAY_CNT_CHECK_EN adds a sticky err output. This flag flags any
//   non-load step of o that changes more than one bit.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              down,
  input  logic              load,
  input  logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  o,
  output logic              wrap,
  gray_counter_if.master    snap
`ifdef GRAY_CNT_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  // ---------------- counter ----------------
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             wrap_nxt;

  always_comb begin
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    if (load) begin
      cnt_nxt = d;
    end else if (en) begin
      if (down) begin
        cnt_nxt  = cnt - ONE;
        wrap_nxt = (cnt == '0);
      end else begin
        cnt_nxt  = cnt + ONE;
        wrap_nxt = (cnt == ALL_ONES);
      end
    end
  end

  // o is encoded from the next count so it never lags cnt by a cycle.
  bin_to_gray #(.WIDTH(WIDTH)) u_bin_to_gray (
    .bin  (cnt_nxt),
    .gray (gray_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      o    <= '0;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      o    <= gray_nxt;
      wrap <= wrap_nxt;
    end
  end

  // ---------------- snapshot FSM ----------------
  snap_state_t      state;
  snap_state_t      state_nxt;
  logic             valid_q;
  logic             valid_nxt;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_nxt;

  always_comb begin
    state_nxt = state;
    valid_nxt = valid_q;
    data_nxt  = data_q;
    case (state)
      S_IDLE: begin
        if (snap.snap_req) begin
          data_nxt  = o;
          valid_nxt = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        // valid is always 1 here, so snap_ready alone marks a transfer.
        if (snap.snap_ready) begin
          if (snap.snap_req) begin
            data_nxt = o;
          end else begin
            valid_nxt = 1'b0;
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state   <= state_nxt;
      valid_q <= valid_nxt;
      data_q  <= data_nxt;
    end
  end

  assign snap.snap_valid = valid_q;
  assign snap.snap_data  = data_q;

`ifdef GRAY_CNT_CHECK_EN
  // ---------------- self-check ----------------
  // skip_prev marks that the step into the current o came from load or reset. Such a step
  // may legally change several bits.
  logic [WIDTH-1:0] o_prev;
  logic             skip_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_prev    <= '0;
      skip_prev <= 1'b1;
      err       <= 1'b0;
    end else begin
      o_prev    <= o;
      skip_prev <= load;
      if (!skip_prev && ($countones(o ^ o_prev) > 1)) begin
        err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter at WIDTH=4 and WIDTH=32.
// An arithmetic reference model is compared every cycle; literal expectations pin the model.
// Ports: none (top-level bench).
module tb_gray_counter;
  import gray_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- WIDTH=4 instance ----------------
  logic       rst4, en4, down4, load4, wrap4;
  logic [3:0] d4, o4;
  gray_counter_if #(.WIDTH(4)) sif4 ();
`ifdef GRAY_CNT_CHECK_EN
  logic err4;
`endif
  gray_counter #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .rst  (rst4),
    .en   (en4),
    .down (down4),
    .load (load4),
    .d    (d4),
    .o    (o4),
    .wrap (wrap4),
    .snap (sif4)
`ifdef GRAY_CNT_CHECK_EN
    ,
    .err  (err4)
`endif
  );

  // ---------------- WIDTH=32 instance ----------------
  logic        rst32, en32, down32, load32, wrap32;
  logic [31:0] d32, o32;
  gray_counter_if #(.WIDTH(32)) sif32 ();
`ifdef GRAY_CNT_CHECK_EN
  logic err32;
`endif
  gray_counter #(.WIDTH(32)) dut32 (
    .clk  (clk),
    .rst  (rst32),
    .en   (en32),
    .down (down32),
    .load (load32),
    .d    (d32),
    .o    (o32),
    .wrap (wrap32),
    .snap (sif32)
`ifdef GRAY_CNT_CHECK_EN
    ,
    .err  (err32)
`endif
  );

  // ---------------- helpers ----------------
  function automatic longint unsigned gray_of(input longint unsigned v);
    return v ^ (v >> 1);
  endfunction

  // Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  localparam longint unsigned MOD4  = 64'd16;
  localparam longint unsigned MOD32 = 64'h1_0000_0000;

  longint unsigned m4 = 0, m32 = 0;
  bit              ok4 = 0, ok32 = 0;
  logic            mw4 = 0, mw32 = 0, msv4 = 0, msv32 = 0;
  longint unsigned msd4 = 0, msd32 = 0;

  always @(posedge clk) begin : model4
    longint unsigned prev_o;
    prev_o = gray_of(m4);
    if (rst4) begin
      m4 = 0; mw4 = 0; msv4 = 0; msd4 = 0; ok4 = 1;
    end else begin
      if (!msv4) begin
        if (sif4.snap_req) begin msv4 = 1; msd4 = prev_o; end
      end else if (sif4.snap_ready) begin
        if (sif4.snap_req) msd4 = prev_o;
        else msv4 = 0;
      end
      mw4 = 0;
      if (load4) m4 = 64'(d4);
      else if (en4) begin
        if (down4) begin mw4 = (m4 == 0); m4 = (m4 + MOD4 - 1) % MOD4; end
        else begin mw4 = (m4 == MOD4 - 1); m4 = (m4 + 1) % MOD4; end
      end
    end
  end

  always @(posedge clk) begin : model32
    longint unsigned prev_o;
    prev_o = gray_of(m32);
    if (rst32) begin
      m32 = 0; mw32 = 0; msv32 = 0; msd32 = 0; ok32 = 1;
    end else begin
      if (!msv32) begin
        if (sif32.snap_req) begin msv32 = 1; msd32 = prev_o; end
      end else if (sif32.snap_ready) begin
        if (sif32.snap_req) msd32 = prev_o;
        else msv32 = 0;
      end
      mw32 = 0;
      if (load32) m32 = 64'(d32);
      else if (en32) begin
        if (down32) begin mw32 = (m32 == 0); m32 = (m32 + MOD32 - 1) % MOD32; end
        else begin mw32 = (m32 == MOD32 - 1); m32 = (m32 + 1) % MOD32; end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (ok4) begin
      chk("model_o4",    32'(o4),              32'(gray_of(m4)));
      chk("model_wrap4", 32'(wrap4),           32'(mw4));
      chk("model_sv4",   32'(sif4.snap_valid), 32'(msv4));
      chk("model_sd4",   32'(sif4.snap_data),  32'(msd4));
`ifdef GRAY_CNT_CHECK_EN
      chk("err4", 32'(err4), 32'd0);
`endif
    end
    if (ok32) begin
      chk("model_o32",    o32,                   32'(gray_of(m32)));
      chk("model_wrap32", 32'(wrap32),           32'(mw32));
      chk("model_sv32",   32'(sif32.snap_valid), 32'(msv32));
      chk("model_sd32",   sif32.snap_data,       32'(msd32));
`ifdef GRAY_CNT_CHECK_EN
      chk("err32", 32'(err32), 32'd0);
`endif
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  logic [3:0] up_seq [18] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                              4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0, 4'h1};
  logic [3:0] dn_seq [6]  = '{4'h6, 4'h2, 4'h3, 4'h1, 4'h0, 4'h8};

  initial begin
    rst4 = 1; en4 = 0; down4 = 0; load4 = 0; d4 = '0;
    sif4.snap_req = 0; sif4.snap_ready = 0;
    rst32 = 1; en32 = 0; down32 = 0; load32 = 0; d32 = '0;
    sif32.snap_req = 0; sif32.snap_ready = 0;
    tick;
    chk("rst_o4",    32'(o4),              32'h0);
    chk("rst_wrap4", 32'(wrap4),           32'h0);
    chk("rst_sv4",   32'(sif4.snap_valid), 32'h0);
    chk("rst_o32",   o32,                  32'h0);

    // Up-count through a full wrap.
    rst4 = 0; rst32 = 0; en4 = 1;
    for (int i = 0; i < 17; i++) begin
      tick;
      chk("up_seq_o4",    32'(o4),    32'(up_seq[i+1]));
      chk("up_seq_wrap4", 32'(wrap4), (i == 15) ? 32'd1 : 32'd0);
    end

    // Load then down-count through 0.
    en4 = 0; load4 = 1; d4 = 4'd5;
    tick;
    chk("load5_o4",    32'(o4),    32'h7);
    chk("load5_wrap4", 32'(wrap4), 32'h0);
    load4 = 0; en4 = 1; down4 = 1;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("dn_seq_o4",    32'(o4),    32'(dn_seq[i]));
      chk("dn_seq_wrap4", 32'(wrap4), (i == 5) ? 32'd1 : 32'd0);
    end

    // Snapshot held while counting continues.
    en4 = 0; down4 = 0; load4 = 1; d4 = 4'd2;
    tick;
    chk("snap_pre_o4", 32'(o4), 32'h3);
    load4 = 0; en4 = 1; sif4.snap_req = 1; sif4.snap_ready = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("snap_hold_sd4", 32'(sif4.snap_data),  32'h3);
      chk("snap_hold_sv4", 32'(sif4.snap_valid), 32'h1);
    end
    chk("snap_cnt_o4", 32'(o4), 32'h5);
    en4 = 0; sif4.snap_req = 0; sif4.snap_ready = 1;
    tick;
    chk("snap_xfer_sv4", 32'(sif4.snap_valid), 32'h0);

    // Back-to-back recapture.
    sif4.snap_ready = 0; sif4.snap_req = 1;
    tick;
    chk("b2b_cap_sd4", 32'(sif4.snap_data), 32'h5);
    sif4.snap_req = 0; en4 = 1;
    tick;
    chk("b2b_stable_sd4", 32'(sif4.snap_data), 32'h5);
    en4 = 0; sif4.snap_ready = 1; sif4.snap_req = 1;
    tick;
    chk("b2b_sv4", 32'(sif4.snap_valid), 32'h1);
    chk("b2b_sd4", 32'(sif4.snap_data),  32'h4);
    sif4.snap_req = 0;
    tick;
    chk("b2b_end_sv4", 32'(sif4.snap_valid), 32'h0);
    sif4.snap_ready = 0;

    // Reset with a pending snapshot and competing load/en.
    load4 = 1; d4 = 4'd8;
    tick;
    chk("pre_rst_o4", 32'(o4), 32'hC);
    load4 = 0; en4 = 1; sif4.snap_req = 1;
    tick;
    chk("pre_rst_sd4", 32'(sif4.snap_data), 32'hC);
    sif4.snap_req = 0; rst4 = 1; en4 = 1; load4 = 1; d4 = 4'd5;
    tick;
    chk("mid_rst_o4",    32'(o4),              32'h0);
    chk("mid_rst_wrap4", 32'(wrap4),           32'h0);
    chk("mid_rst_sv4",   32'(sif4.snap_valid), 32'h0);
    chk("mid_rst_sd4",   32'(sif4.snap_data),  32'h0);
    rst4 = 0; en4 = 0; load4 = 0;

    // WIDTH=32: wrap from all-ones up, then back down.
    load32 = 1; d32 = 32'hFFFF_FFFF;
    tick;
    chk("w32_load_o",    o32,          32'h8000_0000);
    chk("w32_load_wrap", 32'(wrap32),  32'h0);
    load32 = 0; en32 = 1;
    tick;
    chk("w32_up_o",      o32,           32'h0);
    chk("w32_up_wrap",   32'(wrap32),   32'h1);
    chk("w32_decode",    gray2bin(o32), 32'h0);
    down32 = 1;
    tick;
    chk("w32_dn_o",      o32,           32'h8000_0000);
    chk("w32_dn_wrap",   32'(wrap32),   32'h1);
    chk("w32_dn_decode", gray2bin(o32), 32'hFFFF_FFFF);
    en32 = 0;
    tick;
    chk("w32_hold_wrap", 32'(wrap32), 32'h0);
    chk("w32_hold_o",    o32,         32'h8000_0000);

    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Registered up/down binary counter that publishes its value as reflected Gray code.
- Upstream producer for the Gray-to-binary decoder stage.
- Consumers (decoder, CDC pointer paths) see a Gray value that changes by exactly one bit per count step.
- A valid/ready snapshot port lets a slower consumer capture one stable Gray sample at a time.

Parameters:
- WIDTH, 32, counter and Gray output width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  count enable; one step per cycle while high
- down  input  1  direction: 0 = increment, 1 = decrement (sampled only when en=1)
- load  input  1  synchronous load of d
- d  input  WIDTH  binary load value
- o  output  WIDTH  current count, Gray-encoded, registered
- wrap  output  1  one-cycle pulse after the count wraps
- snap_req  input  1  request a snapshot of o
- snap_valid  output  1  snap_data holds an untransferred sample
- snap_ready  input  1  consumer accepts snap_data
- snap_data  output  WIDTH  captured Gray sample

Behaviour:
- Reset: on a rising clk with rst=1:
  - internal binary cnt=0, o=0, wrap=0.
  - snap_valid=0, snap_data=0, snapshot FSM = S_IDLE.
  - All other inputs are ignored that cycle.
  - rst mid-hold discards any pending sample.
- Update priority per edge: rst > load > en > hold.
- load=1: cnt<=d, o<=d^(d>>1), wrap<=0. Load is the only event allowed to change more than one bit of o.
- en=1, down=0: cnt<=cnt+1 mod 2^WIDTH.
- en=1, down=1: cnt<=cnt-1 mod 2^WIDTH.
- Latency: o always equals gray(cnt), with no lag.
  - o is computed from the next cnt value and registered on the same edge.
  - Inputs sampled at edge N appear on o after edge N.
- Hold (en=0, load=0): cnt, o unchanged; wrap<=0.
- wrap: set to 1 for exactly one cycle after an edge where:
  - up-count went from all-ones to 0, or
  - down-count went from 0 to all-ones.
  - Otherwise 0, including on load of any value.
- Snapshot FSM, states S_IDLE, S_HOLD:
  - S_IDLE, snap_req=1: snap_data<=o (value of o before this edge's update), snap_valid<=1, go to S_HOLD.
  - S_HOLD: snap_data and snap_valid stable until snap_valid&snap_ready; snap_req ignored unless a transfer happens in the same cycle.
  - S_HOLD with transfer and snap_req=0: snap_valid<=0, go to S_IDLE.
  - S_HOLD with transfer and snap_req=1: recapture snap_data<=o, stay in S_HOLD with snap_valid=1 (back-to-back, no bubble).
  - snap_ready while in S_IDLE has no effect.
- Snapshot logic never stalls counting; counter and FSM are independent apart from sampling o.

Optional Feature:
- Macro GRAY_CNT_CHECK_EN.
- Defined: adds output port err (1 bit), a sticky self-check flag.
  - Registered previous o and previous load.
  - err<=1 if consecutive o values differ in more than one bit while the previous cycle was not a load or reset.
  - err is cleared only by rst.
- Undefined: port err and its checking logic are absent; no other behavioural change.

Decomposition:
- Package gray_pkg holds:
  - localparam GRAY_W_DEFAULT = 32
  - typedef enum logic {S_IDLE, S_HOLD} snap_state_t
  - function bin2gray(input logic [31:0] b), returning b ^ (b >> 1), masked to width by the caller.
- One natural sub-module, bin_to_gray (combinational, parameter WIDTH). It is instantiated on the next-cnt path so the encoding is shared with the downstream decoder's testbench.

Test Plan:
- WIDTH=4: rst 1 cycle, en=1 down=0 for 17 cycles -> o sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0,1; wrap=1 only in the cycle o returns to 0.
- WIDTH=4: load d=5 -> o=7 next cycle, wrap=0; then en=1 down=1 for 6 cycles -> o=6,2,3,1,0,8; wrap pulses when o goes 0->8.
- WIDTH=32: load d=32'hFFFF_FFFF, en=1 up one step -> o=0, wrap=1; o passed through the Gray-to-binary decoder -> 0.
- Snapshot: o=3, snap_req=1 with snap_ready=0 for 4 cycles while counting -> snap_data=3 stable, snap_valid=1; then snap_ready=1 with snap_req=0 -> snap_valid=0 next cycle.
- Back-to-back: in S_HOLD, snap_ready=1 and snap_req=1 in the same cycle -> snap_valid stays 1 and snap_data updates to the current o.
- Reset mid-operation: count to o=C (WIDTH=4) with a snapshot pending, rst=1 with en=1 load=1 -> o=0, wrap=0, snap_valid=0 after the edge. With GRAY_CNT_CHECK_EN: err stays 0 across all of the above.
